// File: rtl/multi_channel_queue_reg.sv
// Multi-lane register FIFO buffering feature-map words between stages.
// Registered pop data with a valid strobe, sticky error flags, flush.
module multi_channel_queue_reg #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 3,
  parameter int CHANNELS = 1,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      input_vld,
  input  logic [WIDTH*CHANNELS-1:0] din,
  input  logic                      read_flag,
  output logic [WIDTH*CHANNELS-1:0] dout,
  output logic                      out_vld,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int DW = WIDTH * CHANNELS;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_F = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_A = CW'(AF_LEVEL);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;
  logic          cnt_up;
  logic          cnt_dn;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign full        = (count == CNT_F);
  assign empty       = (count == '0);
  assign almost_full = (count >= CNT_A);

  assign pop_ok  = read_flag & ~empty;
  assign push_ok = input_vld & (~full | pop_ok);
  assign cnt_up  = push_ok & ~pop_ok;
  assign cnt_dn  = pop_ok & ~push_ok;

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
      out_vld   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_vld   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out_vld <= pop_ok;
      if (pop_ok) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= nxt(rd_ptr);
      end
      if (push_ok) begin
        wr_ptr <= nxt(wr_ptr);
      end
      unique case (1'b1)
        cnt_up:  count <= count + CW'(1);
        cnt_dn:  count <= count - CW'(1);
        default: count <= count;
      endcase
      if (input_vld && full && !pop_ok) begin
        overflow <= 1'b1;
      end
      if (read_flag && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_queue_reg.sv
// Randomised bench for multi_channel_queue_reg against a queue model.
// Directed fill/drain, overflow, wrap, flush and reset, then random traffic.
module tb_multi_channel_queue_reg;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 3;
  localparam int CHANNELS = 2;
  localparam int AF_LEVEL = 2;
  localparam int DW       = WIDTH * CHANNELS;
  localparam int CW       = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          input_vld = 1'b0;
  logic [DW-1:0] din = '0;
  logic          read_flag = 1'b0;
  logic [DW-1:0] dout;
  logic          out_vld;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q [$];
  logic [DW-1:0] m_dout;
  logic          m_vld;
  logic          m_ovf;
  logic          m_udf;

  multi_channel_queue_reg #(
    .WIDTH(WIDTH), .DEPTH(DEPTH),
    .CHANNELS(CHANNELS), .AF_LEVEL(AF_LEVEL)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .input_vld(input_vld), .din(din),
    .read_flag(read_flag), .dout(dout),
    .out_vld(out_vld), .full(full),
    .empty(empty), .almost_full(almost_full),
    .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_step(
    input logic          r,
    input logic          f,
    input logic          v,
    input logic [DW-1:0] d,
    input logic          rd
  );
    int  n;
    logic pop;
    logic push;
    n = q.size();
    if (r) begin
      q.delete();
      m_dout = '0;
      m_vld  = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else if (f) begin
      q.delete();
      m_vld = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      pop  = rd && (n > 0);
      push = v && ((n < DEPTH) || pop);
      if (rd && n == 0) m_udf = 1'b1;
      if (v && n == DEPTH && !pop) m_ovf = 1'b1;
      m_vld = pop;
      if (pop) m_dout = q.pop_front();
      if (push) q.push_back(d);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("dout", 64'(dout), 64'(m_dout));
    chk("out_vld", 64'(out_vld), 64'(m_vld));
    chk("count", 64'(count), 64'(n));
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("almost_full", 64'(almost_full), 64'(n >= AF_LEVEL));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("underflow", 64'(underflow), 64'(m_udf));
  endtask

  task automatic cyc(
    input logic          r,
    input logic          f,
    input logic          v,
    input logic [DW-1:0] d,
    input logic          rd
  );
    rst       = r;
    flush     = f;
    input_vld = v;
    din       = d;
    read_flag = rd;
    @(posedge clk);
    model_step(r, f, v, d, rd);
    #1;
    check_all();
  endtask

  task automatic push(input logic [DW-1:0] d);
    cyc(1'b0, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    m_dout = '0;
    m_vld  = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;

    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("rst_empty", 64'(empty), 64'd1);

    // Fill and drain
    push(16'h0201);
    push(16'h0403);
    chk("af_at_2", 64'(almost_full), 64'd1);
    push(16'h0605);
    chk("full_at_3", 64'(full), 64'd1);
    pop();
    chk("drain0", 64'(dout), 64'h0201);
    pop();
    chk("drain1", 64'(dout), 64'h0403);
    pop();
    chk("drain2", 64'(dout), 64'h0605);
    idle();
    chk("vld_drop", 64'(out_vld), 64'd0);

    // Overflow on full queue
    push(16'h0201);
    push(16'h0403);
    push(16'h0605);
    push(16'h0807);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_cnt", 64'(count), 64'd3);
    pop();
    pop();
    pop();
    chk("ovf_last", 64'(dout), 64'h0605);

    // Simultaneous push/pop at full and empty
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    push(16'h0201);
    push(16'h0403);
    push(16'h0605);
    cyc(1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b1);
    chk("pp_full_dout", 64'(dout), 64'h0201);
    chk("pp_full_cnt", 64'(count), 64'd3);
    pop();
    pop();
    pop();
    chk("pp_tail", 64'(dout), 64'hAAAA);
    cyc(1'b0, 1'b0, 1'b1, 16'h1111, 1'b1);
    chk("pp_empty_udf", 64'(underflow), 64'd1);
    chk("pp_empty_vld", 64'(out_vld), 64'd0);
    chk("pp_empty_cnt", 64'(count), 64'd1);

    // Wrap-around
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int n = 0; n < 10; n++) begin
      push(DW'(16'h0100 + n));
      pop();
      chk("wrap_dout", 64'(dout), 64'(16'h0100 + n));
    end

    // Flush with both flags set
    pop();
    push(16'h0A0A);
    push(16'h0B0B);
    push(16'h0C0C);
    push(16'h0D0D);
    pop();
    cyc(1'b0, 1'b1, 1'b1, 16'h0E0E, 1'b1);
    chk("flush_dout", 64'(dout), 64'h0A0A);
    chk("flush_ovf", 64'(overflow), 64'd0);
    push(16'h1234);
    pop();
    chk("post_flush", 64'(dout), 64'h1234);

    // Reset mid-operation
    push(16'h5555);
    push(16'h6666);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("midrst_dout", 64'(dout), 64'd0);
    chk("midrst_cnt", 64'(count), 64'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 9) < 6),
          DW'($urandom),
          ($urandom_range(0, 9) < 5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_channel_queue_reg.md
Name: multi_channel_queue_reg

Overview:
Parametrised register-based FIFO carrying CHANNELS parallel lanes of WIDTH bits with shared push/pop control. It buffers feature-map words between conv/pool stages of the MNIST pipeline.
It generalises the single-lane shift-register queue with:
- arbitrary depth with pointer wrap-around
- full/empty/almost-full status and an occupancy count
- simultaneous push/pop when full
- synchronous flush
- sticky overflow/underflow error flags
- a read-valid strobe aligned to the registered output

Parameters:
WIDTH, 8, bits per channel lane
DEPTH, 3, number of entries; any value >= 2, need not be a power of two
CHANNELS, 1, number of parallel lanes stored per entry
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous clear of contents and error flags
input_vld  in  1  push request
din  in  WIDTH*CHANNELS  push data; lane k occupies bits [WIDTH*(k+1)-1 : WIDTH*k]
read_flag  in  1  pop request
dout  out  WIDTH*CHANNELS  registered pop data, same lane packing as din
out_vld  out  1  one-cycle strobe: dout updated by the previous cycle's accepted pop
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky: a push was dropped
underflow  out  1  sticky: a pop was rejected

Behaviour:
- Reset (rst=1 at an edge):
  - count=0 and both pointers=0.
  - dout=0, out_vld=0, overflow=0, underflow=0.
  - full=0, empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), which is effectively 0.
  - Reset overrides every other input, including mid-operation. Storage contents need not be cleared.
- Status outputs full/empty/almost_full are combinational decodes of the registered count. They carry no extra latency.
- Pop accepted: pop_ok = read_flag & ~empty.
- Push accepted: push_ok = input_vld & (~full | pop_ok). A push into a full queue succeeds only if a pop is accepted in the same cycle.
- On push_ok: the din entry is written at wr_ptr, and wr_ptr = (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
- On pop_ok:
  - the entry at rd_ptr is registered into dout at the same edge, and rd_ptr wraps identically to wr_ptr;
  - out_vld=1 in the following cycle and 0 otherwise;
  - read latency is 1 cycle: data is visible the cycle after read_flag is sampled.
- dout holds its last value when there is no accepted pop, including through flush.
- No fall-through: a push and a pop on an empty queue in the same cycle reject the pop. underflow is set, the push is stored, and count becomes 1.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never wraps below 0.
- overflow <= 1 when input_vld & full & ~pop_ok; the din word is discarded.
- underflow <= 1 when read_flag & empty.
- Both flags stay set until rst or flush.
- flush=1 (with rst=0):
  - count=0, pointers=0, overflow=0, underflow=0, out_vld=0;
  - any push or pop in the same cycle is ignored and does not set the flags;
  - dout is held.
- FIFO order is preserved across any number of pointer wrap-arounds. Lanes are never reordered or mixed within an entry.
- Priority: rst > flush > push/pop.
- Synthesis: the storage is a register array with no reset, inferable as distributed RAM. There are no combinational paths from inputs to dout or out_vld.

Test Plan (WIDTH=8, DEPTH=3, CHANNELS=2, AF_LEVEL=2 unless stated):
1. Reset then fill/drain:
   - Push 0x0201, 0x0403, 0x0605 -> count 1,2,3, almost_full at count 2, full at 3.
   - Pop three times -> dout 0x0201, 0x0403, 0x0605, each with out_vld the cycle after its read_flag; empty=1 at the end.
2. Overflow: on a full queue push 0x0807 with no pop -> overflow=1, count stays 3. Subsequent pops return 0x0201, 0x0403, 0x0605 only.
3. Simultaneous push/pop:
   - Full queue, push 0xAAAA with pop -> dout=0x0201, count stays 3.
   - Draining then returns 0x0403, 0x0605, 0xAAAA.
   - Empty queue, push 0x1111 with pop -> underflow=1, out_vld=0, count=1.
4. Wrap-around: 10 cycles of alternating push k / pop with k=0x0100+n -> dout sequence equals push order, count oscillates 1/0, no flags set.
5. Flush with 2 entries plus concurrent push and pop, both flags set -> count=0, empty=1, flags=0, dout unchanged, out_vld=0. The next push/pop returns the newly pushed word.
6. Reset mid-operation: assert rst with queue holding 2 entries while read_flag=1 -> next cycle dout=0, out_vld=0, count=0. Parameter sweep DEPTH=5, CHANNELS=4 repeats scenarios 1 and 4.
